alu_mdu: RTL and testbench

- Parametrised next-generation ALU for the mycpu execute stage.
- Adds XOR, compares and shifts to the add/sub/and/or set, plus an optional iterative multiply/divide unit (MDU).
- Result output is registered and uses a valid/ready handshake, so execute can stall on multi-cycle ops.
- One operation in flight at a time.

---
 rtl/alu_mdu.sv | 212 +++++++++++++++++++++
 tb/tb_alu_mdu.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// Registered ALU for the execute stage with an optional iterative multiply/divide unit.
// A single operation is in flight at a time; results leave through a valid/ready handshake.
module alu_mdu #(
    parameter int WIDTH  = 32,
    parameter int MDU_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       alu_op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REM   = 4'd14;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [SHW-1:0]   cnt_reg, cnt_next;
    logic [3:0]       op_reg, op_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic [WIDTH-1:0] opd_reg, opd_next;
    logic             neg_q_reg, neg_q_next;
    logic             neg_r_reg, neg_r_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;

    assign shamt = src2_i[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_op_i)
            OP_ADD:  alu_res = src1_i + src2_i;
            OP_SUB:  alu_res = src1_i - src2_i;
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_XOR:  alu_res = src1_i ^ src2_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
            OP_SLL:  alu_res = src1_i << shamt;
            OP_SRL:  alu_res = src1_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(src1_i) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // hi:lo is the shared shift register: product for multiply, remainder:quotient for divide.
    logic             is_mul;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] iter_hi, iter_lo, mdu_res;

    assign is_mul    = (op_reg == OP_MUL) || (op_reg == OP_MULHU);
    assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opd_reg} : '0);
    assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opd_reg};

    always_comb begin
        iter_hi = hi_reg;
        iter_lo = lo_reg;
        if (is_mul) begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            iter_hi = div_trial[WIDTH-1:0];
            iter_lo = {lo_reg[WIDTH-2:0], 1'b1};
        end else begin
            iter_hi = div_shift[WIDTH-1:0];
            iter_lo = {lo_reg[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        mdu_res = '0;
        case (op_reg)
            OP_MUL:          mdu_res = iter_lo;
            OP_MULHU:        mdu_res = iter_hi;
            OP_DIV, OP_DIVU: mdu_res = neg_q_reg ? -iter_lo : iter_lo;
            default:         mdu_res = neg_r_reg ? -iter_hi : iter_hi;
        endcase
    end

    logic             signed_div;
    logic [WIDTH-1:0] mag1, mag2;

    assign signed_div = (alu_op_i == OP_DIV) || (alu_op_i == OP_REM);
    assign mag1 = (signed_div && src1_i[WIDTH-1]) ? -src1_i : src1_i;
    assign mag2 = (signed_div && src2_i[WIDTH-1]) ? -src2_i : src2_i;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        opd_next    = opd_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid_i) begin
                    op_next    = alu_op_i;
                    state_next = DONE;
                    if (alu_op_i < OP_MUL) begin
                        result_next = alu_res;
                    end else if (MDU_EN == 0) begin
                        result_next = '0;
                    end else if (alu_op_i >= OP_DIV && src2_i == '0) begin
                        result_next = (alu_op_i == OP_DIV || alu_op_i == OP_DIVU) ? '1 : src1_i;
                    end else if (signed_div && src1_i == MIN_VAL && src2_i == '1) begin
                        result_next = (alu_op_i == OP_DIV) ? MIN_VAL : '0;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = SHW'(WIDTH - 1);
                        hi_next    = '0;
                        if (alu_op_i < OP_DIV) begin
                            lo_next    = src2_i;
                            opd_next   = src1_i;
                            neg_q_next = 1'b0;
                            neg_r_next = 1'b0;
                        end else begin
                            lo_next    = mag1;
                            opd_next   = mag2;
                            neg_q_next = signed_div && (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
                            neg_r_next = signed_div && src1_i[WIDTH-1];
                        end
                    end
                end
            end
            BUSY: begin
                hi_next  = iter_hi;
                lo_next  = iter_lo;
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == '0) begin
                    result_next = mdu_res;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Abort wins over everything, including an accept in the same cycle.
        if (flush_i) begin
            state_next  = IDLE;
            cnt_next    = '0;
            result_next = result_reg;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            op_reg     <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            opd_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
            zero_reg   <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            opd_reg    <= opd_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            result_reg <= result_next;
            zero_reg   <= (result_next == '0);
        end
    end

    assign in_ready_o  = (state_reg == IDLE);
    assign out_valid_o = (state_reg == DONE);
    assign busy_o      = (state_reg == BUSY);
    assign result_o    = result_reg;
    assign zero_o      = zero_reg;
endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed literal cases plus random ops checked every cycle
// against a transaction-level model of the handshake and arithmetic.
module tb_alu_mdu;
    localparam int W = 32;
    localparam logic [W-1:0] MIN_VAL = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic         in_ready, out_valid, zero, busy;
    logic [W-1:0] result;

    int vectors = 0;
    int miscompares = 0;

    alu_mdu #(.WIDTH(W), .MDU_EN(1)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .alu_op_i   (op),
        .src1_i     (src1),
        .src2_i     (src2),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .zero_o     (zero),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] ref_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  return (ua < ub) ? 32'd1 : 32'd0;
            4'd7:  return a << b[4:0];
            4'd8:  return a >> b[4:0];
            4'd9:  return 32'(sa >>> b[4:0]);
            4'd10: return 32'(ua * ub);
            4'd11: return 32'((ua * ub) >> 32);
            4'd12: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            4'd13: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            4'd14: return (b == 0) ? a : 32'(sa % sb);
            default: return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        if (o < 4'd10) return 1;
        if (o >= 4'd12 && b == 0) return 1;
        if ((o == 4'd12 || o == 4'd14) && a == MIN_VAL && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction model: pending op with a due cycle, then a held result until taken.
    int cyc = 0;
    int due = 0;
    bit pend = 0;
    bit act = 0;
    logic [W-1:0] pend_res = '0;
    logic [W-1:0] cur_res = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend = 0;
            act  = 0;
        end else begin
            if (pend && cyc == due) begin
                pend    = 0;
                act     = 1;
                cur_res = pend_res;
            end
            check("out_valid", out_valid, act);
            check("in_ready", in_ready, !pend && !act);
            check("busy", busy, pend);
            if (act) begin
                check("result", result, cur_res);
                check("zero", zero, cur_res == 0);
            end
            if (flush) begin
                pend = 0;
                act  = 0;
            end else if (act && out_ready) begin
                act = 0;
            end else if (!pend && !act && in_valid) begin
                pend     = 1;
                due      = cyc + ref_lat(op, src1, src2);
                pend_res = ref_op(op, src1, src2);
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        in_valid = 1'b1;
        op = o;
        src1 = a;
        src2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 4'($urandom);
        src1 = $urandom;
        src2 = $urandom;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_valid"}, out_valid, 1'b1);
    endtask

    task automatic take(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic directed(input string name, input logic [3:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_wait);
        int n;
        issue(o, a, b);
        wait_done(name, n);
        check({name, "_wait"}, n, exp_wait);
        check(name, result, exp);
        take(0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'hFFFF_FFFF;
            2: return MIN_VAL;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_zero", zero, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_result", result, 32'h0);
        rst_n = 1'b1;

        directed("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 0);
        directed("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 0);
        directed("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
        directed("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
        directed("sra", 4'd9, 32'h8000_0000, 32'h24, 32'hF800_0000, 0);
        directed("mul", 4'd10, 32'h1_0000, 32'h1_0000, 32'h0, W);
        directed("mulhu", 4'd11, 32'h1_0000, 32'h1_0000, 32'h1, W);
        directed("div", 4'd12, -32'd7, 32'd2, 32'hFFFF_FFFD, W);
        directed("rem", 4'd14, -32'd7, 32'd2, 32'hFFFF_FFFF, W);
        directed("divu_by0", 4'd13, 32'd7, 32'd0, 32'hFFFF_FFFF, 0);
        directed("remu_by0", 4'd15, 32'd7, 32'd0, 32'd7, 0);
        directed("div_ovf", 4'd12, MIN_VAL, 32'hFFFF_FFFF, MIN_VAL, 0);
        directed("rem_ovf", 4'd14, MIN_VAL, 32'hFFFF_FFFF, 32'h0, 0);

        issue(4'd0, 32'd40, 32'd2);
        wait_done("hold", n);
        check("hold_result", result, 32'd42);
        take(5);
        check("after_take_ready", in_ready, 1'b1);

        issue(4'd12, 32'd100, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        check("flush_pre_busy", busy, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ready", in_ready, 1'b1);
        check("flush_valid", out_valid, 1'b0);
        repeat (40) begin @(posedge clk); #1; end

        @(posedge clk); #1;
        in_valid = 1'b1; flush = 1'b1; op = 4'd2; src1 = 32'hF0; src2 = 32'h3C;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_accept_ready", in_ready, 1'b1);
        check("flush_accept_valid", out_valid, 1'b0);

        issue(4'd10, 32'd1234, 32'd5678);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_ready", in_ready, 1'b1);
        check("arst_zero", zero, 1'b1);
        check("arst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            logic [3:0] o;
            o = 4'($urandom_range(0, 15));
            issue(o, pick_operand(), pick_operand());
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
            end else begin
                wait_done("rand", n);
                take($urandom_range(0, 3));
            end
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
